// File: rtl/shifter_pkg.sv
// shifter_pkg: fill-mode, direction and state encodings shared by the shifters
package shifter_pkg;
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_ONE = 2'd1;
  localparam logic [1:0] EXT_EDGE = 2'd2;
  localparam logic [1:0] EXT_ROT = 2'd3;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_step1.sv
// shift_step1: one-position shift of word in dir, vacated bit filled per extend (e = latched edge bit)
module shift_step1
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] word,
  input  logic             dir,
  input  logic [1:0]       extend,
  input  logic             e,
  output logic [WIDTH-1:0] word_next
);
  logic fill;
  always_comb begin
    fill = extend == EXT_ZERO ? 1'b0 :
           extend == EXT_ONE  ? 1'b1 :
           extend == EXT_EDGE ? e :
           dir == DIR_RIGHT   ? word[0] : word[WIDTH-1];
    word_next = dir == DIR_RIGHT ? {fill, word[WIDTH-1:1]} : {word[WIDTH-2:0], fill};
  end
endmodule

// File: rtl/shifter_seq.sv
// shifter_seq: bit-serial shifter, req (v/by/dir/extend) -> rsp (result) over valid/ready
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] by,
  input  logic             dir,
  input  logic [1:0]       extend,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  state_t state, state_nx;
  logic [WIDTH-1:0] sr, step;
  logic [CNT_W-1:0] cnt, n;
  logic dir_q, e_q, accept;
  logic [1:0] ext_q;
  shift_step1 #(.WIDTH(WIDTH)) u_step (
    .word(sr), .dir(dir_q), .extend(ext_q), .e(e_q), .word_next(step)
  );
  always_comb begin
    accept = req_valid && state == IDLE;
    n = extend == EXT_ROT ? {1'b0, by[CNT_W-2:0]} :
        by >= WIDTH'(WIDTH) ? CNT_W'(WIDTH) : by[CNT_W-1:0];
    state_nx = state;
    state_nx = state == IDLE  ? (accept ? (n == '0 ? DONE : SHIFT) : IDLE) :
               state == SHIFT ? (cnt == CNT_W'(1) ? DONE : SHIFT) :
               rsp_ready ? IDLE : DONE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      dir_q <= 1'b0;
      ext_q <= 2'd0;
      e_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sr <= v;
        cnt <= n;
        dir_q <= dir;
        ext_q <= extend;
        e_q <= dir == DIR_RIGHT ? v[WIDTH-1] : v[0];
      end else if (state == SHIFT) begin
        sr <= step;
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign result = sr;
endmodule

// File: tb/tb_shifter_seq.sv
// tb_shifter_seq: directed vector table plus backpressure, busy-input, back-to-back and reset sequences
module tb_shifter_seq;
  typedef struct {
    logic [15:0] v;
    logic [15:0] by;
    logic        dir;
    logic [1:0]  ext;
    logic [15:0] exp;
    int          lat;
  } vec_t;
  logic clock = 0, reset_n = 0, req_valid = 0, rsp_ready = 0, dir = 0;
  logic [15:0] v = 0, by = 0;
  logic [1:0] extend = 0;
  logic req_ready, rsp_valid;
  logic [15:0] result;
  int tests = 0, fails = 0;
  vec_t tbl[13];
  shifter_seq #(.WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .v(v), .by(by), .dir(dir), .extend(extend),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .result(result)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_rsp(output int cyc, input bit toggle);
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      if (toggle) begin
        v = 16'($urandom);
        by = 16'($urandom);
        dir = 1'($urandom);
        extend = 2'($urandom);
      end
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask
  task automatic handshake(input string name);
    @(negedge clock);
    rsp_ready = 1;
    @(posedge clock);
    #1;
    rsp_ready = 0;
    check({name, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask
  task automatic run_op(input vec_t t, input bit toggle, input int hold, input string name);
    int cyc;
    logic [15:0] res;
    @(negedge clock);
    v = t.v;
    by = t.by;
    dir = t.dir;
    extend = t.ext;
    req_valid = 1;
    @(posedge clock);
    #1;
    req_valid = 0;
    wait_rsp(cyc, toggle);
    check({name, "_lat"}, cyc, t.lat);
    check({name, "_res"}, {16'd0, result}, {16'd0, t.exp});
    check({name, "_busy"}, {31'd0, req_ready}, 32'd0);
    res = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check({name, "_hold_res"}, {16'd0, result}, {16'd0, res});
      check({name, "_hold_flags"}, {30'd0, req_ready, rsp_valid}, 32'd1);
    end
    handshake(name);
  endtask
  initial begin
    int cyc;
    bit seen;
    tbl[0]  = '{16'hFA0A, 16'h0000, 1'b0, 2'd0, 16'hFA0A, 1};
    tbl[1]  = '{16'hFA0A, 16'h0004, 1'b0, 2'd0, 16'hA0A0, 5};
    tbl[2]  = '{16'hFA0A, 16'h0004, 1'b1, 2'd1, 16'hFFA0, 5};
    tbl[3]  = '{16'hFA0A, 16'h0004, 1'b1, 2'd3, 16'hAFA0, 5};
    tbl[4]  = '{16'hFA0A, 16'h0004, 1'b0, 2'd3, 16'hA0AF, 5};
    tbl[5]  = '{16'h0001, 16'h000E, 1'b0, 2'd2, 16'h7FFF, 15};
    tbl[6]  = '{16'h0001, 16'h0010, 1'b0, 2'd2, 16'hFFFF, 17};
    tbl[7]  = '{16'h0001, 16'h1000, 1'b0, 2'd2, 16'hFFFF, 17};
    tbl[8]  = '{16'h0001, 16'h1000, 1'b1, 2'd2, 16'h0000, 17};
    tbl[9]  = '{16'h1234, 16'h0004, 1'b1, 2'd0, 16'h0123, 5};
    tbl[10] = '{16'hFA0A, 16'h0014, 1'b0, 2'd3, 16'hA0AF, 5};
    tbl[11] = '{16'hFA0A, 16'h0010, 1'b1, 2'd3, 16'hFA0A, 1};
    tbl[12] = '{16'h8001, 16'h0003, 1'b1, 2'd2, 16'hF000, 4};
    #1;
    check("reset_flags", {30'd0, req_ready, rsp_valid}, 32'd2);
    check("reset_result", {16'd0, result}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < 13; i++) run_op(tbl[i], 1'b0, 0, $sformatf("vec%0d", i));
    run_op(tbl[3], 1'b0, 10, "backpressure");
    run_op(tbl[1], 1'b1, 0, "busy_toggle");
    @(negedge clock);
    v = 16'hFA0A;
    by = 16'h0002;
    dir = 1;
    extend = 0;
    req_valid = 1;
    @(posedge clock);
    #1;
    dir = 0;
    wait_rsp(cyc, 1'b0);
    check("b2b_first_lat", cyc, 3);
    check("b2b_first_res", {16'd0, result}, 32'h3E82);
    @(negedge clock);
    rsp_ready = 1;
    @(posedge clock);
    #1;
    rsp_ready = 0;
    check("b2b_no_same_cycle", {30'd0, req_ready, rsp_valid}, 32'd2);
    @(posedge clock);
    #1;
    req_valid = 0;
    check("b2b_second_accept", {31'd0, req_ready}, 32'd0);
    wait_rsp(cyc, 1'b0);
    check("b2b_second_lat", cyc, 3);
    check("b2b_second_res", {16'd0, result}, 32'hE828);
    handshake("b2b");
    @(negedge clock);
    v = 16'hFA0A;
    by = 16'h0008;
    dir = 0;
    extend = 0;
    req_valid = 1;
    @(posedge clock);
    #1;
    req_valid = 0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 0;
    #1;
    check("midrst_flags", {30'd0, req_ready, rsp_valid}, 32'd2);
    check("midrst_result", {16'd0, result}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      #1;
      seen |= rsp_valid;
    end
    check("midrst_no_rsp", {31'd0, seen}, 32'd0);
    run_op(tbl[9], 1'b0, 0, "after_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
